// File: rtl/cmd_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// cmd_tx_scheduler_pkg : shared types, command indices and default parameters
//                        for the command transmit scheduler.
// Revision: 1.0
// ============================================================================
package cmd_tx_scheduler_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT         = 50_000_000;
  localparam int unsigned REPLY_WAIT_TICKS_DEFAULT = CLK_FREQ_DEFAULT / 10000;
  localparam int unsigned GAP_TICKS_DEFAULT        = 16;
  localparam int unsigned MAX_RETRIES_DEFAULT      = 3;

  localparam int unsigned NUM_CMDS    = 3;
  localparam int unsigned TIMER_MIN_W = 13;

  localparam logic [1:0] CMD_SR  = 2'd0;
  localparam logic [1:0] CMD_DPR = 2'd1;
  localparam logic [1:0] CMD_CCW = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_TX         = 3'd2,
    ST_WAIT_REPLY = 3'd3,
    ST_GAP        = 3'd4
  } sched_state_e;

  // Round-robin successor over the three command slots.
  function automatic logic [1:0] next_cmd_idx(input logic [1:0] idx);
    return (idx == CMD_CCW) ? CMD_SR : idx + 2'd1;
  endfunction

  function automatic logic [2:0] cmd_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned need;
    need = $clog2(((a > b) ? a : b) + 1);
    return (need > TIMER_MIN_W) ? need : TIMER_MIN_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_tx_scheduler_timer.sv
`default_nettype none
// ============================================================================
// sched_tick_timer : loadable down-counter with zero flag, shared by the
//                    reply window and the inter-exchange gap.
// Revision: 1.0
// ============================================================================
module sched_tick_timer
  import cmd_tx_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_MIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/cmd_tx_scheduler.sv
`default_nettype none
// ============================================================================
// cmd_tx_scheduler : arbitrates SR/DPR/CCW commands (repeats first, then
//                    round-robin), sequences tx/reply/gap and source switching.
// Revision: 1.0
// ============================================================================
module cmd_tx_scheduler
  import cmd_tx_scheduler_pkg::*;
#(
  parameter int unsigned CLK_FREQ         = CLK_FREQ_DEFAULT,
  parameter int unsigned REPLY_WAIT_TICKS = CLK_FREQ / 10000,
  parameter int unsigned GAP_TICKS        = GAP_TICKS_DEFAULT,
  parameter int unsigned MAX_RETRIES      = MAX_RETRIES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmd_reqs,
  input  logic [2:0] repeat_reqs,
  input  logic       tx_done,
  input  logic       rx_frame_end,
  output logic       tx_start,
  output logic [1:0] tx_sel,
  output logic [2:0] cmd_acks,
  output logic [2:0] delays_after_cmds_for_reply,
  output logic       switch_com_src_req,
  output logic       com_src,
  output logic       sched_busy
);

  localparam int unsigned          TIMER_W     = timer_width(REPLY_WAIT_TICKS, GAP_TICKS);
  localparam logic [TIMER_W-1:0]   REPLY_LOAD  = TIMER_W'(REPLY_WAIT_TICKS - 1);
  localparam logic [TIMER_W-1:0]   GAP_LOAD    = TIMER_W'(GAP_TICKS - 1);
  localparam logic [1:0]           RETRY_LIMIT = 2'(MAX_RETRIES);

  sched_state_e     state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             fresh_q, fresh_d;
  logic [1:0]       rr_q, rr_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0][1:0]  retry_q, retry_d;
  logic             com_src_q, com_src_d;
  logic             switch_q, switch_d;

  logic             grant_vld;
  logic             grant_fresh;
  logic [1:0]       grant_idx;
  logic             grant_take;
  logic [2:0]       overflow;

  logic             tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic             tmr_zero;

  sched_tick_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  // Pending repeats outrank fresh requests; fresh requests rotate from rr_q.
  always_comb begin
    logic [1:0] cand;
    grant_vld   = 1'b0;
    grant_fresh = 1'b0;
    grant_idx   = CMD_SR;
    cand        = rr_q;
    if (|pend_q) begin
      grant_vld = 1'b1;
      if (pend_q[0]) begin
        grant_idx = CMD_SR;
      end else if (pend_q[1]) begin
        grant_idx = CMD_DPR;
      end else begin
        grant_idx = CMD_CCW;
      end
    end else begin
      for (int k = 0; k < int'(NUM_CMDS); k++) begin
        if (!grant_vld && cmd_reqs[cand]) begin
          grant_vld   = 1'b1;
          grant_fresh = 1'b1;
          grant_idx   = cand;
        end
        cand = next_cmd_idx(cand);
      end
    end
  end

  assign grant_take = (state_q == ST_IDLE) && grant_vld;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    fresh_d      = fresh_q;
    rr_d         = rr_q;
    tmr_load     = 1'b0;
    tmr_load_val = REPLY_LOAD;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_START;
          idx_d   = grant_idx;
          fresh_d = grant_fresh;
          rr_d    = next_cmd_idx(grant_idx);
        end
      end
      ST_START: begin
        state_d = ST_TX;
      end
      ST_TX: begin
        if (tx_done) begin
          state_d      = ST_WAIT_REPLY;
          tmr_load     = 1'b1;
          tmr_load_val = REPLY_LOAD;
        end
      end
      ST_WAIT_REPLY: begin
        if (rx_frame_end || tmr_zero) begin
          state_d      = ST_GAP;
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A grant consumes the old pending bit; a same-cycle repeat pulse re-arms it.
  always_comb begin
    pend_d   = pend_q;
    retry_d  = retry_q;
    overflow = 3'b000;
    for (int i = 0; i < int'(NUM_CMDS); i++) begin
      if (grant_take && (grant_idx == 2'(i))) begin
        pend_d[i] = 1'b0;
        if (grant_fresh) begin
          retry_d[i] = 2'd0;
        end else if (retry_q[i] != 2'b11) begin
          retry_d[i] = retry_q[i] + 2'd1;
        end
      end
      if (repeat_reqs[i]) begin
        if (retry_q[i] == RETRY_LIMIT) begin
          overflow[i] = 1'b1;
          retry_d[i]  = 2'd0;
        end else begin
          pend_d[i] = 1'b1;
        end
      end
    end
    switch_d  = |overflow;
    com_src_d = com_src_q ^ (|overflow);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= CMD_SR;
      fresh_q   <= 1'b0;
      rr_q      <= CMD_SR;
      pend_q    <= 3'b000;
      retry_q   <= '0;
      com_src_q <= 1'b0;
      switch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fresh_q   <= fresh_d;
      rr_q      <= rr_d;
      pend_q    <= pend_d;
      retry_q   <= retry_d;
      com_src_q <= com_src_d;
      switch_q  <= switch_d;
    end
  end

  assign tx_start                    = (state_q == ST_START);
  assign tx_sel                      = ((state_q == ST_START) || (state_q == ST_TX)) ? idx_q : 2'd0;
  assign cmd_acks                    = ((state_q == ST_START) && fresh_q) ? cmd_onehot(idx_q) : 3'b000;
  assign delays_after_cmds_for_reply = (state_q == ST_WAIT_REPLY) ? cmd_onehot(idx_q) : 3'b000;
  assign switch_com_src_req          = switch_q;
  assign com_src                     = com_src_q;
  assign sched_busy                  = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/cmd_tx_scheduler.md
CMD_TX_SCHEDULER -- requirements
Module: cmd_tx_scheduler

Interface
REQ-001 SHALL have parameter REPLY_WAIT_TICKS, default CLK_FREQ/10000 (100 us), length of the reply window in clk cycles.
REQ-002 SHALL have parameter GAP_TICKS, default 16, idle cycles between the end of one exchange and the next tx_start.
REQ-003 SHALL have parameter MAX_RETRIES, default 3, number of repeats per command before a source switch.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_reqs  in  3  level request per command: [0]=SR, [1]=DPR, [2]=CCW.
REQ-007 SHALL have port repeat_reqs  in  3  one-cycle repeat pulses, same bit order.
REQ-008 SHALL have port tx_done  in  1  one-cycle pulse at end of command transmission.
REQ-009 SHALL have port rx_frame_end  in  1  one-cycle pulse at end of a received reply frame.
REQ-010 SHALL have port tx_start  out  1  one-cycle transmit strobe.
REQ-011 SHALL have port tx_sel  out  2  encoded command index (0..2), valid from tx_start until tx_done.
REQ-012 SHALL have port cmd_acks  out  3  one-cycle pulse to the requester whose fresh command starts.
REQ-013 SHALL have port delays_after_cmds_for_reply  out  3  one-hot reply-window flag for the command in flight.
REQ-014 SHALL have port switch_com_src_req  out  1  one-cycle source-switch pulse.
REQ-015 SHALL have port com_src  out  1  currently selected communication source.
REQ-016 SHALL have port sched_busy  out  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, START, TX, WAIT_REPLY, GAP.
REQ-018 IDLE: if any repeat_pending bit is set, grant the lowest-index pending repeat; otherwise grant the first cmd_reqs bit found round-robin, starting after the last granted index; move to START.
REQ-019 START (one cycle): assert tx_start; drive tx_sel; pulse cmd_acks[idx] only for a fresh grant; move to TX.
REQ-020 TX: on tx_done, move to WAIT_REPLY and load the timer with REPLY_WAIT_TICKS-1.
REQ-021 WAIT_REPLY: drive delays_after_cmds_for_reply[idx]=1; leave on rx_frame_end or timer==0, whichever is first; move to GAP and load GAP_TICKS-1.
REQ-022 GAP: on timer==0, move to IDLE; the first possible tx_start is GAP_TICKS+1 cycles after WAIT_REPLY exits.
REQ-023 A repeat_reqs[i] pulse SHALL be latched into repeat_pending[i] in any state; repeat_pending[i] clears when i is granted.
REQ-024 Per-command retry_cnt[i] (2 bits, saturating): increments on a repeat grant of i; clears on a fresh grant of i.
REQ-025 If repeat_reqs[i] arrives while retry_cnt[i]==MAX_RETRIES:
  - repeat_pending[i] is not set.
  - retry_cnt[i] clears.
  - switch_com_src_req pulses on the next cycle.
  - com_src toggles on the same cycle.
REQ-026 Simultaneous repeat_reqs[i] and grant of i: the grant consumes the old pending bit; the new pulse re-sets it.
REQ-027 If rx_frame_end and timer expiry occur in the same cycle, exit exactly once to GAP.
REQ-028 tx_done outside TX and rx_frame_end outside WAIT_REPLY SHALL be ignored.
REQ-029 When several switch conditions occur in one cycle, SHALL toggle com_src and pulse switch_com_src_req exactly once.

Reset
REQ-030 On rst=1 at a clock edge SHALL:
  - go to IDLE;
  - clear repeat_pending, retry_cnt, timer and the round-robin pointer (next search starts at SR);
  - clear com_src;
  - drive all outputs to 0.
REQ-031 A reset during START/TX/WAIT_REPLY/GAP SHALL abandon the exchange with no further tx_start or cmd_acks pulse.

Structure
REQ-032 A shared package SHALL hold the state enum, the command index constants (SR=0, DPR=1, CCW=2) and default parameter values.
REQ-033 A single sub-module sched_tick_timer (load, value, zero flag) SHALL serve both the reply window and the gap; width SHALL be 13 bits minimum.

Verification
REQ-034 A bench SHALL cover these directed scenarios:
  - cmd_reqs=3'b111 held -> grant order SR, DPR, CCW, SR, with one cmd_acks pulse each.
  - CCW grant, tx_done, no rx_frame_end -> delays_after_cmds_for_reply=3'b100 for exactly REPLY_WAIT_TICKS cycles, then GAP_TICKS idle cycles.
  - Four consecutive repeat_reqs[2] pulses -> three repeat tx_starts with tx_sel=2 and no cmd_acks; the fourth pulse gives switch_com_src_req=1 for one cycle and com_src 0->1.
  - rx_frame_end 5 cycles into WAIT_REPLY -> window ends after 5 cycles; no timeout.
  - repeat_reqs[1] latched while an SR exchange is in flight and cmd_reqs[0]=1 -> next grant is DPR as a repeat.
  - rst asserted in TX -> next cycle state IDLE, all outputs 0, no tx_start until a new request.
